traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Two-road intersection sequencer (North-South main road, East-West side road) that consumes the single-cycle `Hz_1_Enable` strobe produced by the clock divider.
- Counts strobes to time each light phase and drives registered lamp outputs for both roads.
- The NS green is held until an EW vehicle is detected.
- Sits directly downstream of the divider in the controller top level; all logic is on the same fast clock.

Parameters:
- NS_GREEN_S, 10, minimum NS green duration in strobes (1..255)
- EW_GREEN_S, 6, EW green duration in strobes (1..255)
- YELLOW_S, 3, yellow duration in strobes for either road (1..255)
- ALLRED_S, 2, all-red clearance duration in strobes (1..255)

Ports:
- clock, input, 1, system clock; all state updates on the rising edge
- reset, input, 1, asynchronous active-high reset
- Hz_1_Enable, input, 1, one-clock-wide timing strobe from the divider; each high cycle counts as one second
- ew_car, input, 1, EW vehicle sensor, level-sensitive, already synchronised
- ns_lights, output, 3, NS lamps {red, yellow, green}, one-hot
- ew_lights, output, 3, EW lamps {red, yellow, green}, one-hot
- remaining, output, 8, strobes left in the current phase
- phase, output, 3, current state encoding, for debug and display

Behaviour:

Clocking and reset:
- One clock domain. `reset` asserted asynchronously forces, in the same instant:
  - phase = ALL_RED_B
  - remaining = ALLRED_S
  - ns_lights = 3'b100
  - ew_lights = 3'b100
- Release of `reset` is synchronous to `clock`. The first phase after reset is always ALL_RED_B, then NS_GREEN.
- Reset asserted mid-phase aborts the phase immediately; no partial yellow is completed.

States and encodings:
- NS_GREEN = 0, NS_YELLOW = 1, ALL_RED_A = 2, EW_GREEN = 3, EW_YELLOW = 4, ALL_RED_B = 5.
- Encodings 6 and 7 are illegal. On the next edge they recover to ALL_RED_B with remaining = ALLRED_S.

Timer:
- On entry to a phase, `remaining` is loaded with that phase's duration.
- On each clock edge where Hz_1_Enable = 1 and remaining > 1, `remaining` decrements by 1.
- On an edge where Hz_1_Enable = 1 and remaining == 1, the phase expires:
  - the next phase is entered on that same edge;
  - `remaining` loads the next phase's duration.
- Each phase therefore lasts exactly its parameter count of strobes.
- Edges with Hz_1_Enable = 0 change nothing.

Transitions:
- NS_GREEN -> NS_YELLOW at expiry only if ew_car = 1 on the expiring edge.
  - If ew_car = 0, the FSM stays in NS_GREEN with remaining held at 1.
  - The transition then occurs on the first later strobe edge where ew_car = 1.
  - ew_car is sampled only on strobe edges; pulses between strobes are ignored.
- NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN are unconditional at expiry.

Lamp decode (registered, updated on the same edge as `phase`):
- NS_GREEN: NS = 001, EW = 100
- NS_YELLOW: NS = 010, EW = 100
- ALL_RED_A and ALL_RED_B: NS = 100, EW = 100
- EW_GREEN: NS = 100, EW = 001
- EW_YELLOW: NS = 100, EW = 010

Invariants and edge cases:
- Safety invariant: at no cycle is either road non-red while the other road is non-red.
- Hz_1_Enable held high continuously: every clock edge counts. This is legal and is used to speed up simulation.
- Outputs are stable between strobes, and there are no combinational paths from any input to any output.

Test Plan:
1. Assert reset mid NS_GREEN with Hz_1_Enable strobing every 4 clocks -> outputs go to phase = 5, both lamps = 100, remaining = 2 asynchronously, before the next clock edge. After release, exactly 2 strobes pass before NS_GREEN is entered with remaining = 10.
2. ew_car = 1 constantly, defaults, strobe every 4 clocks -> phase sequence 5,0,3?? is not used; the sequence is 5→0→1→2→3→4→5 with dwell times of 2,10,3,2,6,3,2 strobes. remaining counts 10..1 in NS_GREEN, and the lamp vectors match the decode table on every cycle.
3. ew_car = 0 throughout -> after 10 strobes the FSM stays in NS_GREEN with remaining = 1 for 50 further strobes. Raise ew_car between strobes and drop it before the next strobe -> no transition. Hold ew_car high across a strobe -> NS_YELLOW on that edge, remaining = 3.
4. Hz_1_Enable tied high (overrides = 1,1,1,1) -> each phase lasts exactly 1 clock; the full cycle is 6 clocks. The safety invariant holds every cycle.
5. Hz_1_Enable low for 1000 clocks mid EW_GREEN with remaining = 4 -> remaining, phase and lamps are unchanged throughout.
6. Force phase to 7 via testbench `force`/`release` -> on the next clock edge phase = 5, remaining = ALLRED_S, both lamps = 100.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// Two-road intersection sequencer: times each light phase in Hz_1_Enable strobes
// and drives registered one-hot lamp vectors for the NS main road and EW side road.
module traffic_light_fsm #(
  parameter int unsigned NS_GREEN_S = 10,
  parameter int unsigned EW_GREEN_S = 6,
  parameter int unsigned YELLOW_S   = 3,
  parameter int unsigned ALLRED_S   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Hz_1_Enable,
  input  logic       ew_car,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic [7:0] remaining,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_t;

  localparam logic [7:0] L_NS_GREEN = 8'(NS_GREEN_S);
  localparam logic [7:0] L_EW_GREEN = 8'(EW_GREEN_S);
  localparam logic [7:0] L_YELLOW   = 8'(YELLOW_S);
  localparam logic [7:0] L_ALLRED   = 8'(ALLRED_S);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // State register is kept as raw bits so the illegal codes 6/7 stay representable
  // and the recovery path below is reachable.
  logic [2:0] r_phase;
  logic [7:0] r_remaining;
  logic [2:0] r_ns;
  logic [2:0] r_ew;

  logic [2:0] w_phase_nxt;
  logic [7:0] w_remaining_nxt;
  logic [2:0] w_ns_nxt;
  logic [2:0] w_ew_nxt;
  logic       w_last;

  function automatic logic [7:0] phase_dur(input logic [2:0] s);
    case (s)
      NS_GREEN:  phase_dur = L_NS_GREEN;
      NS_YELLOW: phase_dur = L_YELLOW;
      ALL_RED_A: phase_dur = L_ALLRED;
      EW_GREEN:  phase_dur = L_EW_GREEN;
      EW_YELLOW: phase_dur = L_YELLOW;
      default:   phase_dur = L_ALLRED;
    endcase
  endfunction

  function automatic logic [2:0] phase_succ(input logic [2:0] s);
    case (s)
      NS_GREEN:  phase_succ = NS_YELLOW;
      NS_YELLOW: phase_succ = ALL_RED_A;
      ALL_RED_A: phase_succ = EW_GREEN;
      EW_GREEN:  phase_succ = EW_YELLOW;
      EW_YELLOW: phase_succ = ALL_RED_B;
      default:   phase_succ = NS_GREEN;
    endcase
  endfunction

  // Returns {ns, ew}; anything not explicitly green/yellow is red on both roads.
  function automatic logic [5:0] lamp_decode(input logic [2:0] s);
    case (s)
      NS_GREEN:  lamp_decode = {LAMP_GRN, LAMP_RED};
      NS_YELLOW: lamp_decode = {LAMP_YEL, LAMP_RED};
      EW_GREEN:  lamp_decode = {LAMP_RED, LAMP_GRN};
      EW_YELLOW: lamp_decode = {LAMP_RED, LAMP_YEL};
      default:   lamp_decode = {LAMP_RED, LAMP_RED};
    endcase
  endfunction

  always_comb begin
    w_phase_nxt     = r_phase;
    w_remaining_nxt = r_remaining;
    w_last          = (r_remaining <= 8'd1);
    case (r_phase)
      NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B: begin
        if (Hz_1_Enable) begin
          if (!w_last) begin
            w_remaining_nxt = r_remaining - 8'd1;
          end else if ((r_phase == NS_GREEN) && !ew_car) begin
            // Main road keeps green at its last strobe until a side-road car shows up.
            w_remaining_nxt = 8'd1;
          end else begin
            w_phase_nxt     = phase_succ(r_phase);
            w_remaining_nxt = phase_dur(phase_succ(r_phase));
          end
        end
      end
      default: begin
        w_phase_nxt     = ALL_RED_B;
        w_remaining_nxt = L_ALLRED;
      end
    endcase
    {w_ns_nxt, w_ew_nxt} = lamp_decode(w_phase_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase     <= ALL_RED_B;
      r_remaining <= L_ALLRED;
      r_ns        <= LAMP_RED;
      r_ew        <= LAMP_RED;
    end else begin
      r_phase     <= w_phase_nxt;
      r_remaining <= w_remaining_nxt;
      r_ns        <= w_ns_nxt;
      r_ew        <= w_ew_nxt;
    end
  end

  assign phase     = r_phase;
  assign remaining = r_remaining;
  assign ns_lights = r_ns;
  assign ew_lights = r_ew;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase/elapsed-strobe model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_traffic_light_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hz    = 1'b0;
  logic       car   = 1'b0;
  logic [2:0] ns_l, ew_l, ph;
  logic [7:0] rem;
  logic [2:0] f_ns, f_ew, f_ph;
  logic [7:0] f_rem;

  traffic_light_fsm dut (
    .clock(clock), .reset(reset), .Hz_1_Enable(hz), .ew_car(car),
    .ns_lights(ns_l), .ew_lights(ew_l), .remaining(rem), .phase(ph)
  );

  traffic_light_fsm #(.NS_GREEN_S(1), .EW_GREEN_S(1), .YELLOW_S(1), .ALLRED_S(1)) dut_fast (
    .clock(clock), .reset(reset), .Hz_1_Enable(1'b1), .ew_car(1'b1),
    .ns_lights(f_ns), .ew_lights(f_ew), .remaining(f_rem), .phase(f_ph)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit m_illegal = 1'b0;

  // Model: phase index 0..5 in cycle order plus strobes already spent in it.
  int dur [6] = '{10, 3, 2, 6, 3, 2};
  int m_ph = 5;
  int m_el = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic int ns_exp(int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 4;
  endfunction

  function automatic int ew_exp(int p);
    return (p == 3) ? 1 : (p == 4) ? 2 : 4;
  endfunction

  always @(posedge clock or posedge reset) begin
    int p, e;
    p = m_ph;
    e = m_el;
    if (reset || m_illegal) begin
      p = 5;
      e = 0;
    end else if (hz) begin
      e = e + 1;
      if (e >= dur[p]) begin
        if (p == 0 && !car) e = dur[p] - 1;
        else begin
          p = (p + 1) % 6;
          e = 0;
        end
      end
    end
    m_ph <= p;
    m_el <= e;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("phase", int'(ph), m_ph);
      check("remaining", int'(rem), dur[m_ph] - m_el);
      check("ns_lights", int'(ns_l), ns_exp(m_ph));
      check("ew_lights", int'(ew_l), ew_exp(m_ph));
      check("safety", int'(ns_l == 3'b100 || ew_l == 3'b100), 1);
      check("fast_safety", int'(f_ns == 3'b100 || f_ew == 3'b100), 1);
      check("fast_remaining", int'(f_rem), 1);
    end
  end

  task automatic do_strobe();
    @(negedge clock) hz = 1'b1;
    @(negedge clock) hz = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic measure_dwell(output int n);
    logic [2:0] start;
    start = ph;
    n = 0;
    while (n < 300) begin
      do_strobe();
      n++;
      if (ph != start) break;
    end
  endtask

  int seq_ph [7] = '{5, 0, 1, 2, 3, 4, 5};
  int seq_dw [7] = '{2, 10, 3, 2, 6, 3, 2};

  initial begin
    int n;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_phase", int'(ph), 5);
    check("rst_remaining", int'(rem), 2);
    check("rst_ns", int'(ns_l), 4);
    check("rst_ew", int'(ew_l), 4);
    reset = 1'b0;

    // All strobes: every clock advances one phase.
    for (int i = 0; i < 12; i++) begin
      check("fast_phase", int'(f_ph), (5 + i) % 6);
      @(negedge clock);
    end

    // Full cycle with a car always waiting.
    car = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("seq_phase", int'(ph), seq_ph[i]);
      measure_dwell(n);
      check("seq_dwell", n, seq_dw[i]);
    end
    check("ns_green_entry_rem", int'(rem), 10);

    // Async reset in the middle of NS green.
    repeat (3) do_strobe();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_phase", int'(ph), 5);
    check("async_remaining", int'(rem), 2);
    check("async_ns", int'(ns_l), 4);
    check("async_ew", int'(ew_l), 4);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    measure_dwell(n);
    check("post_reset_dwell", n, 2);
    check("post_reset_phase", int'(ph), 0);
    check("post_reset_rem", int'(rem), 10);

    // No side-road car: NS green holds at remaining 1.
    car = 1'b0;
    repeat (10) do_strobe();
    check("hold_phase", int'(ph), 0);
    check("hold_rem", int'(rem), 1);
    repeat (50) do_strobe();
    check("hold50_phase", int'(ph), 0);
    check("hold50_rem", int'(rem), 1);
    @(negedge clock) car = 1'b1;
    @(negedge clock) car = 1'b0;
    do_strobe();
    check("pulse_ignored", int'(ph), 0);
    car = 1'b1;
    do_strobe();
    check("car_phase", int'(ph), 1);
    check("car_rem", int'(rem), 3);

    // Freeze mid EW green with remaining 4.
    repeat (7) do_strobe();
    check("ewg_phase", int'(ph), 3);
    check("ewg_rem", int'(rem), 4);
    repeat (1000) @(negedge clock);
    check("frozen_phase", int'(ph), 3);
    check("frozen_rem", int'(rem), 4);
    check("frozen_ew", int'(ew_l), 1);
    check("frozen_ns", int'(ns_l), 4);

    // Illegal encoding recovery.
    @(negedge clock);
    #2 chk_en = 1'b0;
    m_illegal = 1'b1;
    force dut.r_phase = 3'd7;
    #1;
    check("forced_phase", int'(ph), 7);
    release dut.r_phase;
    @(posedge clock);
    #1 m_illegal = 1'b0;
    chk_en = 1'b1;
    check("recover_phase", int'(ph), 5);
    check("recover_rem", int'(rem), 2);
    check("recover_ns", int'(ns_l), 4);
    check("recover_ew", int'(ew_l), 4);
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
